// File: rtl/key_cmd_parser_pkg.sv
// Shared keypad definitions for fishbowl key consumers:
// key codes, command targets and parser state encoding.
package key_cmd_parser_pkg;

    localparam logic [3:0] KEY_CLR    = 4'd10;
    localparam logic [3:0] KEY_CANCEL = 4'd11;
    localparam logic [3:0] KEY_SEL_T  = 4'd12;
    localparam logic [3:0] KEY_SEL_F  = 4'd14;
    localparam logic [3:0] KEY_ENTER  = 4'd15;

    typedef enum logic [1:0] {
        TGT_TEMP  = 2'd0,
        TGT_LIGHT = 2'd1,
        TGT_FEED  = 2'd2
    } target_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_sel(input logic [3:0] code);
        return (code >= KEY_SEL_T) && (code <= KEY_SEL_F);
    endfunction

endpackage

// File: rtl/key_event_sync.sv
// Keypad press edge detector: one event per press, code taken
// from the same edge. Held-through-reset keys stay silent.
module key_event_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [3:0] ins,
    output logic       key_evt,
    output logic [3:0] key_code
);

    logic push_d;

    // Resetting to 1 masks a key already down when reset releases
    always_ff @(posedge clk) begin
        if (rst) begin
            push_d <= 1'b1;
        end else begin
            push_d <= push;
        end
    end

    assign key_evt  = push & ~push_d;
    assign key_code = ins;

endmodule

// File: rtl/key_cmd_parser.sv
// Keypad command parser: select key, decimal digits, ENTER,
// producing a range-checked {target, value} command.
module key_cmd_parser
    import key_cmd_parser_pkg::*;
#(
    parameter int MAX_DIGITS  = 3,
    parameter int VAL_W       = 10,
    parameter int TEMP_MAX    = 40,
    parameter int LIGHT_MAX   = 100,
    parameter int FEED_MAX    = 999,
    parameter int TIMEOUT_CYC = 250000000,
    parameter int TMO_W       = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [3:0]       ins,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [1:0]       cmd_target,
    output logic [VAL_W-1:0] cmd_value,
    output logic             entry_active,
    output logic [VAL_W-1:0] disp_value,
    output logic             err
);

    localparam int ND_W = $clog2(MAX_DIGITS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t            state;
    target_t           tgt;
    logic [ND_W-1:0]   ndig;
    logic [TMO_W-1:0]  tmo;
    logic              key_evt;
    logic [3:0]        key_code;
    logic [VAL_W-1:0]  value_next;
    logic [VAL_W-1:0]  limit;

    key_event_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .ins      (ins),
        .key_evt  (key_evt),
        .key_code (key_code)
    );

    // v*10 + d; the digit cap keeps this inside VAL_W
    assign value_next = (disp_value << 3) + (disp_value << 1)
                      + VAL_W'(key_code);

    always_comb begin
        limit = VAL_W'(FEED_MAX);
        unique case (tgt)
            TGT_TEMP:  limit = VAL_W'(TEMP_MAX);
            TGT_LIGHT: limit = VAL_W'(LIGHT_MAX);
            default:   limit = VAL_W'(FEED_MAX);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            tgt          <= TGT_TEMP;
            ndig         <= '0;
            tmo          <= '0;
            disp_value   <= '0;
            cmd_valid    <= 1'b0;
            cmd_target   <= '0;
            cmd_value    <= '0;
            entry_active <= 1'b0;
            err          <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (key_evt && is_sel(key_code)) begin
                        state        <= ST_ENTRY;
                        entry_active <= 1'b1;
                        tgt          <= target_t'(key_code[1:0]);
                        disp_value   <= '0;
                        ndig         <= '0;
                        tmo          <= '0;
                    end
                end
                ST_ENTRY: begin
                    if (key_evt) begin
                        tmo <= '0;
                        unique case (1'b1)
                            is_digit(key_code): begin
                                if (ndig < ND_W'(MAX_DIGITS)) begin
                                    disp_value <= value_next;
                                    ndig       <= ndig + ND_W'(1);
                                end
                            end
                            key_code == KEY_CLR: begin
                                disp_value <= '0;
                                ndig       <= '0;
                            end
                            key_code == KEY_CANCEL: begin
                                state        <= ST_IDLE;
                                entry_active <= 1'b0;
                            end
                            is_sel(key_code): begin
                                tgt        <= target_t'(key_code[1:0]);
                                disp_value <= '0;
                                ndig       <= '0;
                            end
                            key_code == KEY_ENTER: begin
                                state        <= ST_IDLE;
                                entry_active <= 1'b0;
                                if (ndig == '0 || disp_value > limit) begin
                                    err <= 1'b1;
                                end else begin
                                    state      <= ST_OUT;
                                    cmd_valid  <= 1'b1;
                                    cmd_target <= tgt;
                                    cmd_value  <= disp_value;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end else if (tmo == TMO_LAST) begin
                        err          <= 1'b1;
                        state        <= ST_IDLE;
                        entry_active <= 1'b0;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                ST_OUT: begin
                    // Keys are dropped here, even on the accepting edge
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_cmd_parser.sv
// Randomised and directed keystroke bench for key_cmd_parser,
// checked by a queue scoreboard against a keystroke-level model.
module tb_key_cmd_parser;

    localparam int TMO   = 16;
    localparam int VAL_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic [3:0]       ins;
    logic             cmd_ready;
    logic             cmd_valid;
    logic [1:0]       cmd_target;
    logic [VAL_W-1:0] cmd_value;
    logic             entry_active;
    logic [VAL_W-1:0] disp_value;
    logic             err;

    key_cmd_parser #(.TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .ins          (ins),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_target   (cmd_target),
        .cmd_value    (cmd_value),
        .entry_active (entry_active),
        .disp_value   (disp_value),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = err pulse, 1 = cmd_valid rises, 2 = cmd_valid falls
    typedef struct {
        int kind;
        int tgt;
        int val;
        int at;
    } ev_t;

    typedef struct {
        int disp;
        bit act;
        bit rst;
    } cyc_t;

    ev_t  evq[$];
    cyc_t cq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_pct = 0;

    // Keystroke-level reference: mode 0 idle, 1 typing, 2 holding a command
    int m_mode = 0;
    bit m_prev = 1'b1;
    int m_tgt = 0;
    int m_dig[$];
    int m_last = 0;
    int lim[3] = '{40, 100, 999};

    function automatic int digval();
        int v;
        v = 0;
        foreach (m_dig[i]) v = v * 10 + m_dig[i];
        return v;
    endfunction

    task automatic step(input bit p, input int code, input bit rdy, input bit r);
        int n;
        bit ev;
        n = cyc + 1;
        ev = p && !m_prev;
        m_prev = p;
        if (r) begin
            m_prev = 1'b1;
            if (m_mode == 2) evq.push_back('{2, 0, 0, n});
            m_mode = 0;
            m_dig.delete();
        end else if (m_mode == 0) begin
            if (ev && code >= 12 && code <= 14) begin
                m_mode = 1;
                m_tgt = code - 12;
                m_dig.delete();
                m_last = n;
            end
        end else if (m_mode == 1) begin
            if (ev) begin
                m_last = n;
                if (code <= 9) begin
                    if (m_dig.size() < 3) m_dig.push_back(code);
                end else if (code == 10) begin
                    m_dig.delete();
                end else if (code == 11) begin
                    m_mode = 0;
                end else if (code <= 14) begin
                    m_tgt = code - 12;
                    m_dig.delete();
                end else if (m_dig.size() == 0 || digval() > lim[m_tgt]) begin
                    evq.push_back('{0, 0, 0, n});
                    m_mode = 0;
                end else begin
                    evq.push_back('{1, m_tgt, digval(), n});
                    m_mode = 2;
                end
            end else if (n - m_last == TMO) begin
                evq.push_back('{0, 0, 0, n});
                m_mode = 0;
            end
        end else begin
            if (rdy) begin
                evq.push_back('{2, 0, 0, n});
                m_mode = 0;
            end
        end
        cq.push_back('{digval(), m_mode == 1, r});
    endtask

    task automatic cycle(input bit p, input int code, input bit r);
        bit rdy;
        rdy = ($urandom_range(99) < rdy_pct);
        push = p;
        ins = 4'(code);
        cmd_ready = rdy;
        rst = r;
        step(p, code, rdy, r);
        @(negedge clk);
    endtask

    task automatic key(input int code, input int hold, input int gap);
        for (int i = 0; i < hold; i++) cycle(1'b1, code, 1'b0);
        for (int i = 0; i < gap; i++) cycle(1'b0, $urandom_range(15), 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom_range(15), 1'b0);
    endtask

    task automatic do_reset(input int n, input bit p);
        for (int i = 0; i < n; i++) cycle(p, 12, 1'b1);
    endtask

    task automatic got(input int kind, input int tgt, input int val);
        ev_t e;
        n_cmp++;
        if (evq.size() == 0) begin
            n_bad++;
            $display("FAIL event: got kind=%0d tgt=%0d val=%0d at cycle %0d, expected none",
                     kind, tgt, val, cyc);
        end else begin
            e = evq.pop_front();
            if (e.kind != kind || e.at != cyc ||
                (kind == 1 && (e.tgt != tgt || e.val != val))) begin
                n_bad++;
                $display("FAIL event: got kind=%0d tgt=%0d val=%0d cyc=%0d, expected kind=%0d tgt=%0d val=%0d cyc=%0d",
                         kind, tgt, val, cyc, e.kind, e.tgt, e.val, e.at);
            end
        end
    endtask

    task automatic check_cycle();
        cyc_t c;
        n_cmp++;
        if (cq.size() == 0) begin
            n_bad++;
            $display("FAIL per_cycle: no expectation at cycle %0d", cyc);
        end else begin
            c = cq.pop_front();
            if (int'(disp_value) != c.disp || entry_active != c.act) begin
                n_bad++;
                $display("FAIL disp: cycle %0d got disp=%0d act=%0b, expected disp=%0d act=%0b",
                         cyc, disp_value, entry_active, c.disp, c.act);
            end
            if (c.rst) begin
                n_cmp++;
                if (cmd_valid || err || cmd_target != 2'd0 || cmd_value != '0) begin
                    n_bad++;
                    $display("FAIL reset: cycle %0d got valid=%0b err=%0b tgt=%0d val=%0d, expected all 0",
                             cyc, cmd_valid, err, cmd_target, cmd_value);
                end
            end
        end
    endtask

    initial begin
        bit pv;
        int lt;
        int lv;
        pv = 1'b0;
        lt = 0;
        lv = 0;
        forever begin
            @(posedge clk);
            #1;
            check_cycle();
            if (err) got(0, 0, 0);
            if (cmd_valid && !pv) begin
                got(1, int'(cmd_target), int'(cmd_value));
                lt = int'(cmd_target);
                lv = int'(cmd_value);
            end else if (!cmd_valid && pv) begin
                got(2, 0, 0);
            end else if (cmd_valid) begin
                n_cmp++;
                if (int'(cmd_target) != lt || int'(cmd_value) != lv) begin
                    n_bad++;
                    $display("FAIL hold: cycle %0d got tgt=%0d val=%0d, expected tgt=%0d val=%0d",
                             cyc, cmd_target, cmd_value, lt, lv);
                end
            end
            pv = cmd_valid;
        end
    end

    initial begin
        int r;
        int code;
        do_reset(3, 1'b0);

        // Command held while not ready, then accepted
        rdy_pct = 0;
        key(12, 1, 1); key(2, 2, 1); key(5, 1, 2); key(15, 1, 1);
        idle(5);
        rdy_pct = 100;
        idle(3);

        // Long press yields one digit
        rdy_pct = 0;
        key(13, 1, 1); key(7, 20, 2); key(15, 1, 1);
        idle(2);
        rdy_pct = 100;
        idle(3);

        // Out-of-range and empty entries
        key(12, 1, 1); key(4, 1, 1); key(5, 1, 1); key(15, 1, 3);
        key(14, 1, 1); key(1, 1, 1); key(2, 1, 1); key(3, 1, 1);
        key(4, 1, 1); key(15, 1, 3);
        key(14, 1, 1); key(15, 1, 3);

        // Timeout, then a stray ENTER in idle
        key(13, 1, 1); key(9, 1, 20);
        key(15, 1, 3);

        // Timeout edge: event on the last cycle wins, one later expires
        key(13, 1, 1); key(4, 1, 15); key(2, 1, 16);
        idle(2);

        // Limits at the boundary, CLR and CANCEL
        key(12, 1, 1); key(4, 1, 1); key(0, 1, 1); key(15, 1, 3);
        key(13, 1, 1); key(9, 1, 1); key(10, 1, 1); key(1, 1, 1);
        key(0, 1, 1); key(1, 1, 1); key(15, 1, 3);
        key(14, 1, 1); key(9, 1, 1); key(11, 1, 2); key(15, 1, 3);

        // Reset with key held through release
        key(13, 1, 1); key(5, 1, 1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8, 1'b0);
        do_reset(3, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 12, 1'b0);
        idle(2);
        key(12, 1, 1); key(3, 1, 1); key(15, 1, 3);

        // Reset while a command waits
        rdy_pct = 0;
        key(14, 1, 1); key(9, 1, 1); key(15, 1, 3);
        do_reset(2, 1'b0);
        rdy_pct = 100;
        idle(3);

        rdy_pct = 40;
        repeat (300) begin
            r = $urandom_range(99);
            if (r < 2) begin
                do_reset($urandom_range(1, 2), 1'($urandom_range(1)));
            end else begin
                r = $urandom_range(99);
                if (r < 55) code = $urandom_range(9);
                else if (r < 72) code = $urandom_range(12, 14);
                else if (r < 88) code = 15;
                else code = $urandom_range(10, 11);
                key(code, $urandom_range(1, 3),
                    ($urandom_range(9) == 0) ? $urandom_range(13, 18)
                                             : $urandom_range(1, 3));
            end
        end

        rdy_pct = 100;
        idle(25);

        n_cmp++;
        if (evq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected events never seen, required 0", evq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
